// File: rtl/x_buf_pkg.sv
// Shared types and constants for the X input buffer slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package x_buf_pkg;

  localparam int COLS = 4;  // matrix columns = ALU lanes
  localparam int X_W  = 9;  // lane width presented to the ALU

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1
  } state_e;

  // Ceiling log2 usable in constant expressions (port widths, localparams).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/x_buf_bank.sv
// One ROWS x 4 element matrix store with a single write port and a full-row read.
// Latency: write lands on the next clk edge; the row read is combinational.
// Backpressure: none; the owner decides when wr_en may fire.
// Ports: clk; wr_en/wr_addr/wr_data write element wr_addr (row = wr_addr[msb:2],
//   column = wr_addr[1:0]); rd_row selects the row driven on rd_data (4 x DATA_W).
module x_buf_bank
  import x_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ROWS   = 8
) (
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [clog2(ROWS)+1:0]          wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic [clog2(ROWS)-1:0]          rd_row,
  output logic [COLS-1:0][DATA_W-1:0]     rd_data
);

  localparam int RW = clog2(ROWS);

  // Storage is deliberately not reset: validity is tracked by the owner's pointers.
  logic [COLS-1:0][DATA_W-1:0] mem_q [ROWS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr[RW+1:2]][wr_addr[1:0]] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_row];

endmodule

// File: rtl/x_input_buffer.sv
// Collects a ROWS x 4 matrix from a valid/ready element stream and presents it row by row.
// Latency: row 0 appears one cycle after the last element is accepted; rows advance on x_shift.
// Backpressure: in_ready is registered and depends only on state; it drops while no bank can take data.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready element stream (row-major);
//   x_shift advances the row; mat_ready flags valid x_reg1..x_reg4 (zero-extended to 9 bits);
//   row_idx is the row on x_reg*; mat_done pulses with the x_shift that retires the last row.
// Build option X_PINGPONG_EN: second bank fills while the first drains, swapping without a bubble.
module x_input_buffer
  import x_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ROWS   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    x_shift,
  output logic                    mat_ready,
  output logic [X_W-1:0]          x_reg1,
  output logic [X_W-1:0]          x_reg2,
  output logic [X_W-1:0]          x_reg3,
  output logic [X_W-1:0]          x_reg4,
  output logic [clog2(ROWS)-1:0]  row_idx,
  output logic                    mat_done
);

  localparam int RW = clog2(ROWS);
  localparam int AW = RW + 2;

`ifdef X_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  state_e                        state_q, state_d;
  logic [AW-1:0]                 wp_q, wp_d;
  logic [RW-1:0]                 rp_q, rp_d;
  logic                          in_ready_q, in_ready_d;
  logic                          mat_ready_q;
  logic [COLS-1:0][X_W-1:0]      x_q, x_d;

  logic                          xfer;
  logic                          fill_last;
  logic [NB-1:0]                 wr_en;
  logic [COLS-1:0][DATA_W-1:0]   rd_data [NB];
  logic [COLS-1:0][DATA_W-1:0]   drain_row;

  assign xfer      = in_valid && in_ready_q;
  // ROWS is a power of two, so the last element address is all ones.
  assign fill_last = xfer && (&wp_q);

  for (genvar b = 0; b < NB; b++) begin : g_bank
    x_buf_bank #(.DATA_W(DATA_W), .ROWS(ROWS)) u_bank (
      .clk     (clk),
      .wr_en   (wr_en[b]),
      .wr_addr (wp_q),
      .wr_data (in_data),
      .rd_row  (rp_d),
      .rd_data (rd_data[b])
    );
  end

`ifdef X_PINGPONG_EN
  // sel_q is the bank being filled; the other bank is the one drained in READY.
  logic sel_q, sel_d;
  // The fill bank is complete and waiting for the drain bank to finish.
  logic idle_full_q, idle_full_d;

  assign wr_en      = {xfer && sel_q, xfer && !sel_q};
  assign drain_row  = sel_d ? rd_data[0] : rd_data[1];
  assign in_ready_d = !idle_full_d;
`else
  assign wr_en      = xfer;
  assign drain_row  = rd_data[0];
  assign in_ready_d = (state_d == FILL);
`endif

  always_comb begin
    state_d = state_q;
    rp_d    = rp_q;
    wp_d    = xfer ? wp_q + AW'(1) : wp_q;
`ifdef X_PINGPONG_EN
    sel_d       = sel_q;
    idle_full_d = idle_full_q;
`endif
    case (state_q)
      FILL: begin
        if (fill_last) begin
          state_d = READY;
`ifdef X_PINGPONG_EN
          sel_d = ~sel_q;
`endif
        end
      end
      READY: begin
`ifdef X_PINGPONG_EN
        if (fill_last) idle_full_d = 1'b1;
`endif
        if (x_shift) begin
          rp_d = rp_q + RW'(1);  // wraps to row 0 after the last row
          if (&rp_q) begin
`ifdef X_PINGPONG_EN
            // A bank completing on this very edge also counts as full.
            if (idle_full_q || fill_last) begin
              sel_d       = ~sel_q;
              idle_full_d = 1'b0;
            end else begin
              state_d = FILL;
            end
`else
            state_d = FILL;
`endif
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Output row is loaded from the row that will be current after this edge.
  always_comb begin
    x_d = '0;
    for (int c = 0; c < COLS; c++) begin
      x_d[c] = (state_d == READY) ? X_W'(drain_row[c]) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      wp_q        <= '0;
      rp_q        <= '0;
      in_ready_q  <= 1'b1;
      mat_ready_q <= 1'b0;
      x_q         <= '0;
`ifdef X_PINGPONG_EN
      sel_q       <= 1'b0;
      idle_full_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      in_ready_q  <= in_ready_d;
      mat_ready_q <= (state_d == READY);
      x_q         <= x_d;
`ifdef X_PINGPONG_EN
      sel_q       <= sel_d;
      idle_full_q <= idle_full_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mat_ready = mat_ready_q;
  assign x_reg1    = x_q[0];
  assign x_reg2    = x_q[1];
  assign x_reg3    = x_q[2];
  assign x_reg4    = x_q[3];
  assign row_idx   = rp_q;
  assign mat_done  = (state_q == READY) && x_shift && (&rp_q);

endmodule
